// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM -> WB bus. The MEM side (master) drives the *_i signals and
// the pipeline controls; the write-back stage (slave) drives the *_o register
// file / forwarding signals and the retired-instruction count.
//   Controls : stall_i, flush_i
//   MEM slot : valid_i, regwrite_i, memtoreg_i, rdaddr_i, alu_result_i,
//              memdata_i, load_type_i
//   WB slot  : valid_o, regwrite_o, RDaddr_o, RDdata_o, retired_o
interface wb_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
);
    localparam int unsigned RD_W = 5;
    localparam int unsigned LT_W = 3;

    logic              stall_i;
    logic              flush_i;
    logic              valid_i;
    logic              regwrite_i;
    logic              memtoreg_i;
    logic [RD_W-1:0]   rdaddr_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] memdata_i;
    logic [LT_W-1:0]   load_type_i;

    logic              valid_o;
    logic              regwrite_o;
    logic [RD_W-1:0]   RDaddr_o;
    logic [DATA_W-1:0] RDdata_o;
    logic [CNT_W-1:0]  retired_o;

    modport master (
        output stall_i, flush_i, valid_i, regwrite_i, memtoreg_i,
               rdaddr_i, alu_result_i, memdata_i, load_type_i,
        input  valid_o, regwrite_o, RDaddr_o, RDdata_o, retired_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, regwrite_i, memtoreg_i,
               rdaddr_i, alu_result_i, memdata_i, load_type_i,
        output valid_o, regwrite_o, RDaddr_o, RDdata_o, retired_o
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back data path.
// Captures the MEM-stage result each cycle (flush > stall > capture), formats
// load data, drives the register file write port and counts retired
// instructions.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active-high
//   bus    - wb_stage_if.slave (MEM-side inputs, WB-side outputs)
// Optional feature macro: WB_SUBWORD_LOAD_EN
//   defined   : LB/LBU/LH/LHU extraction and extension, little-endian, using
//               alu_result_i[1:0] as the byte offset; other codes act as LW
//   undefined : load_type_i ignored, memory word passes through unchanged
module wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    wb_stage_if.slave  bus
);
    localparam int unsigned RD_W = 5;

    logic              valid_q;
    logic              regwrite_q;
    logic [RD_W-1:0]   rd_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  retired_q;

    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] wdata_c;
    logic              regwrite_c;

`ifdef WB_SUBWORD_LOAD_EN
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Sub-word extraction; halfword select ignores address bit 0.
    always_comb begin
        byte_c      = 8'(bus.memdata_i >> {bus.alu_result_i[1:0], 3'b000});
        half_c      = bus.alu_result_i[1] ? bus.memdata_i[31:16] : bus.memdata_i[15:0];
        load_data_c = bus.memdata_i;
        case (bus.load_type_i)
            LT_LB:   load_data_c = {{24{byte_c[7]}}, byte_c};
            LT_LBU:  load_data_c = {24'd0, byte_c};
            LT_LH:   load_data_c = {{16{half_c[15]}}, half_c};
            LT_LHU:  load_data_c = {16'd0, half_c};
            default: load_data_c = bus.memdata_i;
        endcase
    end
`else
    logic unused_load_type;

    // Full-word loads only; load type has no effect.
    always_comb begin
        load_data_c = bus.memdata_i;
    end
    assign unused_load_type = ^bus.load_type_i;
`endif

    // Write-data mux and $0 write suppression (so $0 is never forwarded).
    always_comb begin
        wdata_c    = bus.memtoreg_i ? load_data_c : bus.alu_result_i;
        regwrite_c = bus.valid_i & bus.regwrite_i & (bus.rdaddr_i != RD_W'(0));
    end

    // Stage register and retire counter; an entry retires when it leaves WB
    // without being held or squashed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            retired_q  <= '0;
        end else begin
            if (valid_q && !bus.stall_i && !bus.flush_i) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (bus.flush_i) begin
                valid_q    <= 1'b0;
                regwrite_q <= 1'b0;
                rd_q       <= '0;
                data_q     <= '0;
            end else if (!bus.stall_i) begin
                valid_q    <= bus.valid_i;
                regwrite_q <= regwrite_c;
                rd_q       <= bus.rdaddr_i;
                data_q     <= wdata_c;
            end
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.regwrite_o = regwrite_q;
    assign bus.RDaddr_o   = rd_q;
    assign bus.RDdata_o   = data_q;
    assign bus.retired_o  = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage. The driver issues one directed
// vector per clock and pushes the expected WB-slot contents; a monitor pops
// and compares on the falling edge.
module tb_wb_stage;
    localparam int unsigned CNT_W = 4;
`ifdef WB_SUBWORD_LOAD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if #(.DATA_W(32), .CNT_W(CNT_W)) bus ();
    wb_stage #(.DATA_W(32), .CNT_W(CNT_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    endfunction

    // One clock: drive inputs on the falling edge, then model the capture.
    task automatic step(input logic st, input logic fl, input logic v, input logic rw,
                        input logic mtr, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [2:0] lt, input logic [31:0] exp_data);
        @(negedge clk);
        bus.stall_i = st;      bus.flush_i = fl;     bus.valid_i = v;
        bus.regwrite_i = rw;   bus.memtoreg_i = mtr; bus.rdaddr_i = rd;
        bus.alu_result_i = alu; bus.memdata_i = mem; bus.load_type_i = lt;
        @(posedge clk);
        if (cur.valid && !st && !fl) cur.ret = cur.ret + 4'd1;
        if (fl) begin
            cur.valid = 1'b0; cur.regwrite = 1'b0; cur.rd = '0; cur.data = '0;
        end else if (!st) begin
            cur.valid = v; cur.regwrite = v & rw & (rd != 5'd0); cur.rd = rd; cur.data = exp_data;
        end
        exp_q.push_back(cur);
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
        step(0, 0, 1, 1, 0, rd, val, 32'hDEAD_BEEF, 3'b001, val);
    endtask

    task automatic load_op(input logic [2:0] lt, input logic [1:0] off,
                           input logic [31:0] exp_sub);
        step(0, 0, 1, 1, 1, 5'd9, {30'h100, off}, 32'h80FF_7F01, lt,
             SUBWORD ? exp_sub : 32'h80FF_7F01);
    endtask

    task automatic bubble();
        step(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b000, 32'h0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
        chk({tag, "_regwrite"}, 32'(bus.regwrite_o), 32'd0);
        chk({tag, "_rdaddr"}, 32'(bus.RDaddr_o), 32'd0);
        chk({tag, "_rddata"}, bus.RDdata_o, 32'd0);
        chk({tag, "_retired"}, 32'(bus.retired_o), 32'd0);
    endtask

    task automatic reset_release();
        exp_q.delete();
        cur = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare the WB slot once per cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid_o", 32'(bus.valid_o), 32'(e.valid));
                chk("regwrite_o", 32'(bus.regwrite_o), 32'(e.regwrite));
                chk("RDaddr_o", 32'(bus.RDaddr_o), 32'(e.rd));
                chk("RDdata_o", bus.RDdata_o, e.data);
                chk("retired_o", 32'(bus.retired_o), 32'(e.ret));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall_i = 0; bus.flush_i = 0; bus.valid_i = 0; bus.regwrite_i = 0;
        bus.memtoreg_i = 0; bus.rdaddr_i = '0; bus.alu_result_i = '0;
        bus.memdata_i = '0; bus.load_type_i = '0;
        cur = '0;
        #1;
        check_zero("reset");
        reset_release();

        // ALU write-back, then $0 suppression.
        alu_op(5'd5, 32'h0000_1234);
        alu_op(5'd0, 32'hFFFF_FFFF);
        bubble();

        // Entry A held for three stalls (changing inputs must be ignored).
        alu_op(5'd7, 32'h0000_A5A5);
        step(1, 0, 1, 1, 0, 5'd3, 32'h1111_1111, 32'h0, 3'b000, 32'h1111_1111);
        step(1, 0, 1, 1, 0, 5'd4, 32'h2222_2222, 32'h0, 3'b000, 32'h2222_2222);
        step(1, 0, 0, 0, 0, 5'd6, 32'h3333_3333, 32'h0, 3'b000, 32'h3333_3333);
        alu_op(5'd8, 32'h0000_0808);
        // Stall and flush together: bubble wins, no retire.
        step(1, 1, 1, 1, 0, 5'd10, 32'h4444_4444, 32'h0, 3'b000, 32'h4444_4444);
        // Store-like entry (no regwrite) still retires.
        step(0, 0, 1, 0, 0, 5'd11, 32'h5555_5555, 32'h0, 3'b000, 32'h5555_5555);

        // Load formatting with memdata 0x80FF_7F01.
        load_op(3'b001, 2'd2, 32'hFFFF_FFFF);
        load_op(3'b010, 2'd3, 32'h0000_0080);
        load_op(3'b011, 2'd2, 32'hFFFF_80FF);
        load_op(3'b100, 2'd0, 32'h0000_7F01);
        load_op(3'b001, 2'd1, 32'h0000_007F);
        load_op(3'b011, 2'd3, 32'hFFFF_80FF);
        load_op(3'b000, 2'd1, 32'h80FF_7F01);
        load_op(3'b111, 2'd2, 32'h80FF_7F01);
        bubble();

        // Asynchronous reset while a valid entry is stalled.
        alu_op(5'd12, 32'h0000_00C0);
        step(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b000, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        reset_release();

        // Counter wrap: 17 back-to-back retirements with CNT_W=4.
        for (int i = 0; i < 17; i++) alu_op(5'(i + 1), 32'(i));
        bubble();
        @(negedge clk);
        chk("wrap_retired", 32'(bus.retired_o), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
